hdpldadapt_rx_datapath_pulse_unstretch: RTL

Receive-end companion to the TX datapath pulse stretcher. It recovers single-cycle event pulses for frame, burst-enable execute and wordslip execute from their stretched level versions. The same stage-count setting that sized the stretch sets the blanking window. It also registers the stretched FIFO empty/partial-empty flags, and flags any event lost because it arrived inside a blanking window. The block sits on the slow-side datapath, in the same clock domain as the stretched signals; no synchronisation is done here.

---
 rtl/hdpldadapt_rx_datapath_pulse_unstretch.sv | 105 ++++++++++
 1 files changed

// File: rtl/hdpldadapt_rx_datapath_pulse_unstretch.sv
// hdpldadapt_rx_datapath_pulse_unstretch
// Recovers single-cycle event pulses (frame, burst-enable execute, wordslip
// execute) from their stretched level versions produced on the TX side.
// After each accepted event, a blanking window of N edges follows. N is the
// same stretch setting that sized the pulse. Any rising edge that lands
// inside that window is reported on a sticky per-channel lost_err bit. The
// stretched FIFO empty/partial-empty flags are only registered, never
// de-stretched, because their level is meaningful for its whole duration.
// Every output is driven straight from a flop.

module hdpldadapt_rx_datapath_pulse_unstretch (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] r_stretch_num_stages,
    input  logic       clr_lost_err,
    input  logic       tx_frame_stretch,
    input  logic       tx_burst_en_exe_stretch,
    input  logic       tx_wordslip_exe_stretch,
    input  logic       rd_empty_stretch,
    input  logic       rd_pempty_stretch,
    output logic       tx_frame_pulse,
    output logic       tx_burst_en_exe_pulse,
    output logic       tx_wordslip_exe_pulse,
    output logic       rd_empty,
    output logic       rd_pempty,
    output logic [2:0] lost_err
);

    localparam int NCH = 3;

    // Channel order matches lost_err bit order: 0 frame, 1 burst-en, 2 wordslip
    logic [NCH-1:0]      evt_p0;
    logic [NCH-1:0][2:0] cnt_p1;
    logic [NCH-1:0]      prev_p1;
    logic [NCH-1:0]      pulse_p1;
    logic [NCH-1:0]      lost_p1;
    logic                empty_p1;
    logic                pempty_p1;

    assign evt_p0 = {tx_wordslip_exe_stretch, tx_burst_en_exe_stretch, tx_frame_stretch};

    // Blank counter step; only called while the count is non-zero, but held
    // at zero defensively so it can never wrap.
    function automatic logic [2:0] cnt_dec(input logic [2:0] c);
        return (c == 3'd0) ? 3'd0 : c - 3'd1;
    endfunction

    // A rising edge is a lost event only while the channel is blanking
    function automatic logic is_lost(input logic prev, input logic cur,
                                     input logic [2:0] c);
        return !prev && cur && (c != 3'd0);
    endfunction

    // ---- stage p0 -> p1: per-channel accept/blank, lost tracking ----
    // Per-channel de-stretch: accept on an idle counter, then blank N edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_p1   <= '0;
            prev_p1  <= '0;
            pulse_p1 <= '0;
            lost_p1  <= '0;
        end else begin
            prev_p1 <= evt_p0;
            for (int i = 0; i < NCH; i++) begin
                if (cnt_p1[i] == 3'd0) begin
                    // Idle counter: a high input is a new event. N is sampled
                    // here only, so a mid-window change waits for this point.
                    pulse_p1[i] <= evt_p0[i];
                    if (evt_p0[i]) begin
                        cnt_p1[i] <= r_stretch_num_stages;
                    end
                end else begin
                    pulse_p1[i] <= 1'b0;
                    cnt_p1[i]   <= cnt_dec(cnt_p1[i]);
                end

                // Setting has priority over the clear so no event is missed
                if (is_lost(prev_p1[i], evt_p0[i], cnt_p1[i])) begin
                    lost_p1[i] <= 1'b1;
                end else if (clr_lost_err) begin
                    lost_p1[i] <= 1'b0;
                end
            end
        end
    end

    // Registered flag copies; reset reports the FIFO as empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            empty_p1  <= 1'b1;
            pempty_p1 <= 1'b1;
        end else begin
            empty_p1  <= rd_empty_stretch;
            pempty_p1 <= rd_pempty_stretch;
        end
    end

    assign tx_frame_pulse        = pulse_p1[0];
    assign tx_burst_en_exe_pulse = pulse_p1[1];
    assign tx_wordslip_exe_pulse = pulse_p1[2];
    assign lost_err              = lost_p1;
    assign rd_empty              = empty_p1;
    assign rd_pempty             = pempty_p1;

endmodule
